// File: rtl/tick_uart_tx.sv
// Tick-paced UART transmitter with a one-entry holding register in front of
// the shift register, so one frame can be on the line while one more waits.
//   clk_in    system clock, all state on its rising edge
//   rst_n     asynchronous active-low reset
//   tick_in   bit-rate enable; one bit time per tick
//   tx_data   word to send, captured on accept
//   tx_valid  producer has tx_data available
//   tx_ready  holding register empty (accept = tx_valid & tx_ready on an edge)
//   tx_out    serial line, mark level 1
//   tx_busy   FSM is not idle
module tick_uart_tx #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 tx_busy
);

    localparam int unsigned      CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q,      state_d;
    logic [DATA_BITS-1:0] hold_data_q,  hold_data_d;
    logic                 hold_empty_q, hold_empty_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic                 parity_q,     parity_d;
    logic [CNT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic                 stop_cnt_q,   stop_cnt_d;
    logic                 tx_out_q,     tx_out_d;
    logic                 busy_q;
    logic                 load_c;

    assign tx_ready = hold_empty_q;
    assign tx_out   = tx_out_q;
    assign tx_busy  = busy_q;

    // State and datapath registers
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            hold_data_q  <= '0;
            hold_empty_q <= 1'b1;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            tx_out_q     <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_data_q  <= hold_data_d;
            hold_empty_q <= hold_empty_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_out_q     <= tx_out_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    // Next-state: line and FSM move only on ticks; holding register on accept
    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        hold_empty_d = hold_empty_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        tx_out_d     = tx_out_q;
        load_c       = 1'b0;

        if (tick_in) begin
            case (state_q)
                S_IDLE: begin
                    tx_out_d = 1'b1;
                    load_c   = !hold_empty_q;
                end
                S_START: begin
                    tx_out_d  = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
                S_DATA: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY != 0) begin
                            tx_out_d = parity_q;
                            state_d  = S_PARITY;
                        end else begin
                            tx_out_d = 1'b1;
                            state_d  = S_STOP;
                        end
                    end else begin
                        tx_out_d  = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                S_PARITY: begin
                    tx_out_d   = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = S_STOP;
                end
                S_STOP: begin
                    if (stop_cnt_q == LAST_STOP) begin
                        // Queued word chains straight into its start bit
                        if (!hold_empty_q) begin
                            load_c = 1'b1;
                        end else begin
                            tx_out_d = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_out_d = 1'b1;
                    state_d  = S_IDLE;
                end
            endcase
        end

        // Load and accept are exclusive: load needs holding full, accept empty
        if (load_c) begin
            shift_d      = hold_data_q;
            parity_d     = (^hold_data_q) ^ (PARITY == 2);
            hold_empty_d = 1'b1;
            tx_out_d     = 1'b0;
            state_d      = S_START;
        end else if (tx_valid && hold_empty_q) begin
            hold_data_d  = tx_data;
            hold_empty_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: five parameter variants share one stimulus stream;
// a frame-level model per variant predicts line, ready and busy each cycle.
module tb_tick_uart_tx;

    localparam int N = 5;

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b1;
    logic         tick_in = 1'b0;
    logic         tx_valid = 1'b0;
    logic [7:0]   tx_data = 8'h00;
    logic [N-1:0] tx_ready_w;
    logic [N-1:0] tx_out_w;
    logic [N-1:0] tx_busy_w;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    tick_uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready_w[0]), .tx_out(tx_out_w[0]), .tx_busy(tx_busy_w[0]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready_w[1]), .tx_out(tx_out_w[1]), .tx_busy(tx_busy_w[1]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready_w[2]), .tx_out(tx_out_w[2]), .tx_busy(tx_busy_w[2]));
    tick_uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready_w[3]), .tx_out(tx_out_w[3]), .tx_busy(tx_busy_w[3]));
    tick_uart_tx #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u_dut4 (
        .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .tx_data(tx_data[4:0]),
        .tx_valid(tx_valid), .tx_ready(tx_ready_w[4]), .tx_out(tx_out_w[4]), .tx_busy(tx_busy_w[4]));

    // Per-variant parameters, matching the instances above
    function automatic int db(int d);
        return (d == 4) ? 5 : 8;
    endfunction
    function automatic int pb(int d);
        case (d)
            1:       return 1;
            2:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic int sb(int d);
        return (d >= 3) ? 2 : 1;
    endfunction
    function automatic int frame_len(int d);
        return 1 + db(d) + ((pb(d) != 0) ? 1 : 0) + sb(d);
    endfunction

    // Whole frame, first line bit in bit 0: start, data LSB first, parity, stops
    function automatic logic [15:0] frame_bits(int d, logic [7:0] data);
        logic [15:0] f;
        logic        par;
        int          k;
        f    = '1;
        f[0] = 1'b0;
        k    = 1;
        par  = 1'b0;
        for (int i = 0; i < db(d); i++) begin
            f[k] = data[i];
            par  = par ^ data[i];
            k++;
        end
        if (pb(d) == 1)      f[k] = par;
        else if (pb(d) == 2) f[k] = ~par;
        return f;
    endfunction

    // Reference model: a bit stream of the frame in flight plus a queued word
    logic [N-1:0] m_out   = '1;
    logic [N-1:0] m_busy  = '0;
    logic [N-1:0] m_ready = '1;
    logic [N-1:0] m_acc;
    logic [7:0]   m_hold [N];
    logic [15:0]  m_bits [N];
    int           m_left [N];

    initial begin
        forever begin
            @(posedge clk_in or negedge rst_n);
            if (!rst_n) begin
                for (int d = 0; d < N; d++) begin
                    m_out[d] = 1'b1; m_busy[d] = 1'b0; m_ready[d] = 1'b1;
                    m_left[d] = 0; m_bits[d] = '1; m_hold[d] = 8'h00;
                end
            end else begin
                for (int d = 0; d < N; d++) m_acc[d] = tx_valid && m_ready[d];
                for (int d = 0; d < N; d++) begin
                    if (tick_in) begin
                        if (m_left[d] > 0) begin
                            m_out[d]  = m_bits[d][0];
                            m_bits[d] = m_bits[d] >> 1;
                            m_left[d] = m_left[d] - 1;
                            m_busy[d] = 1'b1;
                        end else if (!m_ready[d]) begin
                            m_bits[d]  = frame_bits(d, m_hold[d]);
                            m_out[d]   = m_bits[d][0];
                            m_bits[d]  = m_bits[d] >> 1;
                            m_left[d]  = frame_len(d) - 1;
                            m_ready[d] = 1'b1;
                            m_busy[d]  = 1'b1;
                        end else begin
                            m_out[d]  = 1'b1;
                            m_busy[d] = 1'b0;
                        end
                    end
                    if (m_acc[d]) begin
                        m_hold[d]  = tx_data;
                        m_ready[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, return just after the rise
    task automatic cycle(input logic tk, input logic vl, input logic [7:0] dt);
        @(negedge clk_in);
        tick_in  = tk;
        tx_valid = vl;
        tx_data  = dt;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (tx_out_w[d] !== 1'b1 || tx_ready_w[d] !== 1'b1 || tx_busy_w[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset dut%0d out/ready/busy got %b%b%b want 110", d,
                         tx_out_w[d], tx_ready_w[d], tx_busy_w[d]);
            end
        end
        @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [15:0] seen [N];
        int          busy_cnt [N];
        int          nt;
        logic        tk;
        for (int d = 0; d < N; d++) begin seen[d] = '0; busy_cnt[d] = 0; end
        nt = 0;
        cycle(1'b0, 1'b1, 8'hA5);
        for (int c = 0; c < 52; c++) begin
            tk = (c % 4 == 3);
            cycle(tk, 1'b0, 8'h00);
            for (int d = 0; d < N; d++) begin
                n_checks++;
                if (tx_out_w[d] !== m_out[d] || tx_ready_w[d] !== m_ready[d] || tx_busy_w[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL basic dut%0d t=%0t out/ready/busy got %b%b%b want %b%b%b", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_out[d], m_ready[d], m_busy[d]);
                end
            end
            if (tk && nt < 12) begin
                for (int d = 0; d < N; d++) begin
                    seen[d][nt] = tx_out_w[d];
                    busy_cnt[d] += int'(tx_busy_w[d]);
                end
                nt++;
            end
        end
        n_checks++;
        if (seen[0][9:0] !== 10'h34A) begin
            n_fail++;
            $display("FAIL basic_a5_line got %b want %b (first bit rightmost)", seen[0][9:0], 10'h34A);
        end
        n_checks++;
        if (seen[1][9] !== 1'b0) begin
            n_fail++;
            $display("FAIL even_parity got %b want 0", seen[1][9]);
        end
        n_checks++;
        if (seen[2][9] !== 1'b1) begin
            n_fail++;
            $display("FAIL odd_parity got %b want 1", seen[2][9]);
        end
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (busy_cnt[d] != frame_len(d)) begin
                n_fail++;
                $display("FAIL basic_busy_ticks dut%0d got %0d want %0d", d, busy_cnt[d], frame_len(d));
            end
        end
    endtask

    task automatic test_tick_same_edge();
        int busy_cnt [N];
        cycle(1'b1, 1'b1, 8'h3C);
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (tx_out_w[d] !== 1'b1 || tx_ready_w[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL same_edge_accept dut%0d out/ready got %b%b want 10", d, tx_out_w[d], tx_ready_w[d]);
            end
        end
        cycle(1'b1, 1'b0, 8'h00);
        for (int d = 0; d < N; d++) begin
            busy_cnt[d] = int'(tx_busy_w[d]);
            n_checks++;
            if (tx_out_w[d] !== 1'b0 || tx_busy_w[d] !== 1'b1) begin
                n_fail++;
                $display("FAIL same_edge_start dut%0d out/busy got %b%b want 01", d, tx_out_w[d], tx_busy_w[d]);
            end
        end
        for (int c = 0; c < 14; c++) begin
            cycle(1'b1, 1'b0, 8'h00);
            for (int d = 0; d < N; d++) begin
                busy_cnt[d] += int'(tx_busy_w[d]);
                n_checks++;
                if (tx_out_w[d] !== m_out[d] || tx_ready_w[d] !== m_ready[d] || tx_busy_w[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL tick_high dut%0d t=%0t out/ready/busy got %b%b%b want %b%b%b", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_out[d], m_ready[d], m_busy[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (busy_cnt[d] != frame_len(d)) begin
                n_fail++;
                $display("FAIL tick_high_frame_cycles dut%0d got %0d want %0d", d, busy_cnt[d], frame_len(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int   run [N];
        logic started [N];
        logic ended [N];
        logic tk;
        for (int d = 0; d < N; d++) begin run[d] = 0; started[d] = 1'b0; ended[d] = 1'b0; end
        cycle(1'b0, 1'b1, 8'h00);
        for (int c = 0; c < 120; c++) begin
            tk = (c % 4 == 3);
            cycle(tk, (c == 8), 8'hFF);
            for (int d = 0; d < N; d++) begin
                n_checks++;
                if (tx_out_w[d] !== m_out[d] || tx_ready_w[d] !== m_ready[d] || tx_busy_w[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL back_to_back dut%0d t=%0t out/ready/busy got %b%b%b want %b%b%b", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_out[d], m_ready[d], m_busy[d]);
                end
                if (tk && !ended[d]) begin
                    if (tx_busy_w[d]) begin started[d] = 1'b1; run[d]++; end
                    else if (started[d]) ended[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (run[d] != 2 * frame_len(d)) begin
                n_fail++;
                $display("FAIL back_to_back_busy_run dut%0d got %0d ticks want %0d", d, run[d], 2 * frame_len(d));
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic tk;
        cycle(1'b0, 1'b1, 8'hA5);
        for (int c = 0; c <= 20; c++) begin
            tk = (c % 4 == 3);
            cycle(tk, (c == 6), 8'h5A);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (tx_out_w[d] !== 1'b1 || tx_ready_w[d] !== 1'b1 || tx_busy_w[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL midframe_reset dut%0d out/ready/busy got %b%b%b want 110", d,
                         tx_out_w[d], tx_ready_w[d], tx_busy_w[d]);
            end
        end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tk = (c % 4 == 3);
            cycle(tk, 1'b0, 8'h00);
            for (int d = 0; d < N; d++) begin
                n_checks++;
                if (tx_out_w[d] !== 1'b1 || tx_busy_w[d] !== 1'b0 || tx_ready_w[d] !== m_ready[d]) begin
                    n_fail++;
                    $display("FAIL after_reset_idle dut%0d t=%0t out/ready/busy got %b%b%b want 1%b0", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_ready[d]);
                end
            end
        end
    endtask

    task automatic test_reset_release();
        logic tk;
        #2 rst_n = 1'b0;
        @(negedge clk_in);
        rst_n    = 1'b1;
        tick_in  = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'hC3;
        @(posedge clk_in);
        #1;
        for (int d = 0; d < N; d++) begin
            n_checks++;
            if (tx_ready_w[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL first_edge_accept dut%0d ready got %b want 0", d, tx_ready_w[d]);
            end
        end
        for (int c = 0; c < 60; c++) begin
            tk = (c % 4 == 3);
            cycle(tk, 1'b0, 8'h00);
            for (int d = 0; d < N; d++) begin
                n_checks++;
                if (tx_out_w[d] !== m_out[d] || tx_ready_w[d] !== m_ready[d] || tx_busy_w[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL release_frame dut%0d t=%0t out/ready/busy got %b%b%b want %b%b%b", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_out[d], m_ready[d], m_busy[d]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic tk;
        logic vl;
        logic hi_mode;
        hi_mode = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) hi_mode = ($urandom_range(0, 2) == 0);
            tk = hi_mode ? 1'b1 : ($urandom_range(0, 3) == 0);
            vl = ($urandom_range(0, 1) == 1);
            cycle(tk, vl, 8'($urandom));
            for (int d = 0; d < N; d++) begin
                n_checks++;
                if (tx_out_w[d] !== m_out[d] || tx_ready_w[d] !== m_ready[d] || tx_busy_w[d] !== m_busy[d]) begin
                    n_fail++;
                    $display("FAIL random dut%0d t=%0t out/ready/busy got %b%b%b want %b%b%b", d, $time,
                             tx_out_w[d], tx_ready_w[d], tx_busy_w[d], m_out[d], m_ready[d], m_busy[d]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_tick_same_edge();
        test_back_to_back();
        test_reset_midframe();
        test_reset_release();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tick_uart_tx.md
TICK_UART_TX -- requirements
Module: tick_uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-002 Parameter PARITY, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
REQ-003 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 tick_in  input  1  bit-rate enable from the clock divider; every clk_in cycle with tick_in=1 is one tick.
REQ-007 tx_data  input  DATA_BITS  byte to transmit; sampled on accept.
REQ-008 tx_valid  input  1  producer has tx_data available.
REQ-009 tx_ready  output  1  holding register empty; accept occurs on a clock edge with tx_valid=1 and tx_ready=1.
REQ-010 tx_out  output  1  serial line; idle/mark level 1.
REQ-011 tx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 The block SHALL contain a one-entry holding register (data + full flag) and a separate shift register, giving one frame in flight plus one frame queued.
REQ-013 tx_ready SHALL equal NOT holding-full, driven from a register with no combinational path from tx_valid.
REQ-014 On accept, tx_data SHALL be captured and holding-full set on that edge; tx_ready is low from the next cycle.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY=0.
REQ-016 tx_out and FSM state SHALL change only on edges where tick_in=1, except for reset.
REQ-017 IDLE: tx_out=1; on a tick with holding full: move holding to shift register, clear holding-full, tx_out=0, go to START.
REQ-018 START: on next tick, drive data bit 0 (LSB first), go to DATA with bit counter = 0.
REQ-019 DATA: each tick outputs the next bit; after bit DATA_BITS-1 has lasted one tick, drive parity (go to PARITY) or 1 (go to STOP).
REQ-020 Parity bit SHALL be the XOR of the data bits (even), or its inverse (odd).
REQ-021 STOP: tx_out=1 for STOP_BITS ticks; on the tick ending the last stop bit, if holding full, go directly to START (tx_out=0, no idle bit); else go to IDLE.
REQ-022 Each bit SHALL last exactly one tick interval, i.e. from one tick edge to the next tick edge.
REQ-023 Accept and tick on the same edge while IDLE with holding empty: data is queued; start bit is driven on the following tick, not the same edge.
REQ-024 An accept while a frame is in flight SHALL NOT disturb the current frame.
REQ-025 tick_in held high SHALL advance one bit per clk_in cycle.
REQ-026 tx_busy SHALL be low only in IDLE; it stays high across back-to-back frames.

Reset
REQ-027 rst_n=0 SHALL immediately force tx_out=1, tx_busy=0, tx_ready=1, FSM=IDLE, holding cleared, counters 0, independent of clk_in.
REQ-028 Reset mid-frame SHALL abandon the frame and the queued byte; no partial frame resumes after release.
REQ-029 After rst_n rises, the first accept SHALL be possible on the first clk_in edge.

Verification
REQ-030 DATA_BITS=8, PARITY=0, accept 0xA5, ticks every 4 clocks -> tx_out per tick: 0,1,0,1,0,0,1,0,1,1 (10 ticks); tx_busy high for 10 ticks.
REQ-031 PARITY=1 with 0xA5 -> parity bit 0; PARITY=2 -> parity bit 1; parity placed after bit 7, before stop.
REQ-032 Accept 0x00, then 0xFF while the first frame is in flight -> stop of frame 1 is followed directly by the start of frame 2; tx_busy never drops between frames; tx_ready rises when frame 2 loads.
REQ-033 Reset asserted at data bit 3 with a byte queued -> tx_out=1 and tx_ready=1 asynchronously; next tick after release leaves tx_out=1.
REQ-034 tick_in tied high, STOP_BITS=2, accept 0x3C -> full 11-bit frame completes in 11 clk_in cycles after the start edge.
REQ-035 Accept coincident with tick in IDLE -> tx_out stays 1 on that edge; start bit appears on the next tick.
